// File: rtl/round_timer_ctrl.sv
// Round scheduler for the 0-9 s countdown Timer: loads and releases the Timer each round,
// detects hit/miss, accumulates a saturating score and freezes the display during SHOW.
module round_timer_ctrl #(
    parameter int ROUND_SEC  = 4,
    parameter int NUM_ROUNDS = 5,
    parameter int SHOW_CYC   = 25000000,
    parameter int SCORE_W    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               answer,
    input  logic [3:0]         cur_sec,
    output logic               tmr_set,
    output logic [3:0]         tmr_sec,
    output logic [3:0]         round,
    output logic [SCORE_W-1:0] score,
    output logic               hit,
    output logic               miss,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_SHOW = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int CNT_W = $clog2(SHOW_CYC + 1);
    localparam int SUM_W = ((SCORE_W > 4) ? SCORE_W : 4) + 1;

    localparam logic [3:0]       LOAD_SEC   = 4'(ROUND_SEC);
    localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [SUM_W-1:0] SCORE_MAX  = SUM_W'((64'd1 << SCORE_W) - 64'd1);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [CNT_W-1:0]   show_cnt;
    logic [3:0]         rem;
    logic [3:0]         rem_nxt;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic               game_start;
    logic               run_miss;
    logic               run_hit;
    logic               show_end;
    logic               last_round;

    // A timeout beats a simultaneous answer, so run_hit requires a nonzero cur_sec.
    assign game_start = start && ((state == S_IDLE) || (state == S_DONE));
    assign run_miss   = (state == S_RUN) && (cur_sec == 4'd0);
    assign run_hit    = (state == S_RUN) && (cur_sec != 4'd0) && answer;
    assign show_end   = (state == S_SHOW) && (show_cnt == SHOW_LAST);
    assign last_round = (round == LAST_ROUND);

    always_comb begin
        score_sum = SUM_W'(score) + SUM_W'(cur_sec);
        if (score_sum > SCORE_MAX) begin
            score_sat = {SCORE_W{1'b1}};
        end else begin
            score_sat = score_sum[SCORE_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (game_start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_RUN;
            S_RUN:   if (run_miss || run_hit) state_nxt = S_SHOW;
            S_SHOW:  if (show_end) state_nxt = last_round ? S_DONE : S_LOAD;
            S_DONE:  if (game_start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rem_nxt = rem;
        if (run_miss) begin
            rem_nxt = 4'd0;
        end else if (run_hit) begin
            rem_nxt = cur_sec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            show_cnt <= '0;
        end else if (run_miss || run_hit) begin
            show_cnt <= '0;
        end else if (state == S_SHOW) begin
            show_cnt <= show_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= 4'd0;
        end else begin
            rem <= rem_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round <= 4'd0;
        end else if (game_start) begin
            round <= 4'd0;
        end else if (show_end && !last_round) begin
            round <= round + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score <= '0;
        end else if (game_start) begin
            score <= '0;
        end else if (run_hit) begin
            score <= score_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit  <= 1'b0;
            miss <= 1'b0;
        end else begin
            hit  <= run_hit;
            miss <= run_miss;
        end
    end

    // Timer drive follows the state being entered so it is valid in that state's first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_set <= 1'b1;
            tmr_sec <= LOAD_SEC;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tmr_set <= (state_nxt != S_RUN);
            tmr_sec <= ((state_nxt == S_SHOW) || (state_nxt == S_DONE)) ? rem_nxt : LOAD_SEC;
            busy    <= (state_nxt == S_LOAD) || (state_nxt == S_RUN) || (state_nxt == S_SHOW);
            done    <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Self-checking bench for round_timer_ctrl: a 4-cycle-tick Timer model closes the loop,
// and a round-level behavioural model is compared against two DUTs (6-bit and 2-bit score).
module tb_round_timer_ctrl;

    localparam int RS = 3;
    localparam int NR = 2;
    localparam int SC = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       answer = 1'b0;
    logic [3:0] cur_sec;

    logic       tmr_set, hit, miss, busy, done;
    logic [3:0] tmr_sec, round;
    logic [5:0] score;

    logic       tmr_set_b, hit_b, miss_b, busy_b, done_b;
    logic [3:0] tmr_sec_b, round_b;
    logic [1:0] score_b;

    int total = 0;
    int bad   = 0;
    int tick;

    bit m_busy, m_done, m_load, m_run, m_hit, m_miss;
    int m_show_left, m_rem, m_round, m_score6, m_score2;

    round_timer_ctrl #(.ROUND_SEC(RS), .NUM_ROUNDS(NR), .SHOW_CYC(SC), .SCORE_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .answer(answer), .cur_sec(cur_sec),
        .tmr_set(tmr_set), .tmr_sec(tmr_sec), .round(round), .score(score),
        .hit(hit), .miss(miss), .busy(busy), .done(done)
    );

    round_timer_ctrl #(.ROUND_SEC(RS), .NUM_ROUNDS(NR), .SHOW_CYC(SC), .SCORE_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .answer(answer), .cur_sec(cur_sec),
        .tmr_set(tmr_set_b), .tmr_sec(tmr_sec_b), .round(round_b), .score(score_b),
        .hit(hit_b), .miss(miss_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Countdown Timer: set loads new_sec, otherwise one second elapses every 4 cycles, holding at 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sec <= 4'(RS);
            tick    <= 0;
        end else if (tmr_set) begin
            cur_sec <= tmr_sec;
            tick    <= 0;
        end else if (tick == 3) begin
            tick <= 0;
            if (cur_sec != 4'd0) cur_sec <= cur_sec - 4'd1;
        end else begin
            tick <= tick + 1;
        end
    end

    function automatic int sat_add(input int s, input int c, input int max);
        return (s + c > max) ? max : s + c;
    endfunction

    // Round-level model: a game is busy from start until the last result phase expires.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_load <= 0; m_run <= 0; m_hit <= 0; m_miss <= 0;
            m_show_left <= 0; m_rem <= 0; m_round <= 0; m_score6 <= 0; m_score2 <= 0;
        end else begin
            m_hit  <= 0;
            m_miss <= 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1; m_done <= 0; m_load <= 1;
                    m_round <= 0; m_score6 <= 0; m_score2 <= 0;
                end
            end else if (m_load) begin
                m_load <= 0;
                m_run  <= 1;
            end else if (m_run) begin
                if (cur_sec == 4'd0) begin
                    m_run <= 0; m_show_left <= SC; m_miss <= 1; m_rem <= 0;
                end else if (answer) begin
                    m_run <= 0; m_show_left <= SC; m_hit <= 1; m_rem <= int'(cur_sec);
                    m_score6 <= sat_add(m_score6, int'(cur_sec), 63);
                    m_score2 <= sat_add(m_score2, int'(cur_sec), 3);
                end
            end else if (m_show_left > 1) begin
                m_show_left <= m_show_left - 1;
            end else begin
                m_show_left <= 0;
                if (m_round == NR - 1) begin
                    m_busy <= 0;
                    m_done <= 1;
                end else begin
                    m_round <= m_round + 1;
                    m_load  <= 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int exp_sec;
        exp_sec = (m_show_left > 0 || m_done) ? m_rem : RS;
        checkOutput("m_tmr_set", 32'(tmr_set), 32'(!m_run));
        checkOutput("m_tmr_sec", 32'(tmr_sec), exp_sec);
        checkOutput("m_round", 32'(round), m_round);
        checkOutput("m_score", 32'(score), m_score6);
        checkOutput("m_hit", 32'(hit), 32'(m_hit));
        checkOutput("m_miss", 32'(miss), 32'(m_miss));
        checkOutput("m_busy", 32'(busy), 32'(m_busy));
        checkOutput("m_done", 32'(done), 32'(m_done));
        checkOutput("m_tmr_sec_b", 32'(tmr_sec_b), exp_sec);
        checkOutput("m_round_b", 32'(round_b), m_round);
        checkOutput("m_score_b", 32'(score_b), m_score2);
        checkOutput("m_flags_b", {28'd0, hit_b, miss_b, busy_b, done_b},
                    {28'd0, m_hit, m_miss, m_busy, m_done});
        checkOutput("m_tmr_set_b", 32'(tmr_set_b), 32'(!m_run));
    end

    task automatic applyStimulus(input bit s, input bit a);
        start  = s;
        answer = a;
        @(negedge clk);
        start  = 1'b0;
        answer = 1'b0;
    endtask

    task automatic waitRunSec(input int sec);
        bit found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (!tmr_set && cur_sec == 4'(sec)) found = 1;
            else applyStimulus(0, 0);
        end
        if (!found) checkOutput("timeout_run_sec", 0, sec);
    endtask

    task automatic waitFlag(input string name, input int which);
        bit found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            if ((which == 0 && miss) || (which == 1 && done)) found = 1;
            else applyStimulus(0, 0);
        end
        if (!found) checkOutput(name, 0, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("idle_tmr_set", 32'(tmr_set), 1);
        checkOutput("idle_tmr_sec", 32'(tmr_sec), 3);
        checkOutput("idle_busy", 32'(busy), 0);

        // Hit path, plus an answer during SHOW that must be ignored.
        applyStimulus(1, 0);
        checkOutput("load_busy", 32'(busy), 1);
        waitRunSec(2);
        applyStimulus(0, 1);
        checkOutput("hit_pulse", 32'(hit), 1);
        checkOutput("hit_score", 32'(score), 2);
        checkOutput("hit_tmr_sec", 32'(tmr_sec), 2);
        applyStimulus(0, 1);
        checkOutput("show_ans_hit", 32'(hit), 0);
        checkOutput("show_ans_score", 32'(score), 2);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("show_hold_sec", 32'(tmr_sec), 2);
        applyStimulus(0, 0);
        checkOutput("next_round", 32'(round), 1);
        checkOutput("next_load_sec", 32'(tmr_sec), 3);

        // Start during RUN is ignored, then the round times out.
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        checkOutput("run_start_set", 32'(tmr_set), 0);
        checkOutput("run_start_round", 32'(round), 1);
        waitFlag("timeout_miss", 0);
        checkOutput("miss_hit", 32'(hit), 0);
        checkOutput("miss_score", 32'(score), 2);
        checkOutput("miss_tmr_sec", 32'(tmr_sec), 0);
        waitFlag("timeout_done", 1);
        checkOutput("done_round", 32'(round), 1);
        checkOutput("done_score", 32'(score), 2);

        // Answer in the same cycle cur_sec reaches 0.
        applyStimulus(1, 0);
        checkOutput("restart_score", 32'(score), 0);
        waitRunSec(0);
        applyStimulus(0, 1);
        checkOutput("tie_miss", 32'(miss), 1);
        checkOutput("tie_hit", 32'(hit), 0);
        checkOutput("tie_score", 32'(score), 0);
        waitFlag("timeout_done2", 1);

        // Full game with hits at 3 and 1; the 2-bit score saturates.
        applyStimulus(1, 0);
        waitRunSec(3);
        applyStimulus(0, 1);
        waitRunSec(1);
        applyStimulus(0, 1);
        checkOutput("game_score", 32'(score), 4);
        checkOutput("game_score_sat", 32'(score_b), 3);
        waitFlag("timeout_done3", 1);
        checkOutput("game_done", 32'(done), 1);
        checkOutput("game_round", 32'(round), 1);
        applyStimulus(1, 0);
        checkOutput("regame_round", 32'(round), 0);
        checkOutput("regame_score", 32'(score), 0);
        checkOutput("regame_busy", 32'(busy), 1);

        // Two hits at 3, then reset in the middle of round 1's RUN.
        waitRunSec(3);
        applyStimulus(0, 1);
        waitRunSec(3);
        applyStimulus(0, 1);
        checkOutput("two3_score", 32'(score), 6);
        checkOutput("two3_score_sat", 32'(score_b), 3);
        waitFlag("timeout_done4", 1);
        applyStimulus(1, 0);
        waitRunSec(3);
        applyStimulus(0, 1);
        waitRunSec(2);
        #2 rst_n = 1'b0;
        applyStimulus(0, 0);
        checkOutput("rst_tmr_set", 32'(tmr_set), 1);
        checkOutput("rst_tmr_sec", 32'(tmr_sec), 3);
        checkOutput("rst_round", 32'(round), 0);
        checkOutput("rst_score", 32'(score), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        #2 rst_n = 1'b1;
        applyStimulus(0, 0);

        // Random traffic, with occasional resets, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                applyStimulus(0, 0);
                #2 rst_n = 1'b1;
            end else begin
                applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
